// File: rtl/canvas_mem_arbiter.sv
// Arbiter for the single-port canvas pixel memory: scan-out reads win,
// drawing writes are posted through a small FIFO, and a clear FSM sweeps the canvas.
module canvas_mem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 2,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              do_start;
  logic              clr_step;
  logic              clr_last;

  // Queued writes are dropped on clr_start, so nothing drains in that cycle either.
  assign wr_ready  = rst_n && (count < CNT_W'(FIFO_DEPTH)) && (state == IDLE) && !clr_start;
  assign push      = wr_valid && wr_ready;
  assign do_start  = (state == IDLE) && clr_start;
  assign clr_step  = (state == CLEAR) && !scan_req;
  assign clr_last  = clr_step && (clr_cnt == '1);
  assign pop       = (state == IDLE) && !clr_start && !scan_req && (count != '0);
  assign scan_data = mem_rdata;

  // Memory port: scan read, else clear write, else FIFO head write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (scan_req) begin
        mem_en   = 1'b1;
        mem_addr = scan_addr;
      end else if (clr_step) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
      end else if (pop) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[rd_ptr];
        mem_wdata = fifo_data[rd_ptr];
      end
    end
  end

  // Clear FSM and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      scan_valid <= 1'b0;
    end else begin
      scan_valid <= scan_req;
      clr_done   <= clr_last;
      if (do_start) begin
        state    <= CLEAR;
        clr_busy <= 1'b1;
      end else if (clr_last) begin
        state    <= IDLE;
        clr_busy <= 1'b0;
      end
      if (clr_step) clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (do_start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_canvas_mem_arbiter.sv
// Scoreboard bench for canvas_mem_arbiter: a queue/array reference model predicts
// each cycle's memory access and status; a monitor compares the DUT against it.
module tb_canvas_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 2;
  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scan_req = 1'b0, wr_valid = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] scan_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic scan_valid, wr_ready, clr_busy, clr_done, mem_en, mem_we;
  logic [DW-1:0] scan_data, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  canvas_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_valid(scan_valid), .scan_data(scan_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  // Behavioural synchronous single-port RAM attached to the DUT.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct packed {
    bit rdy; bit en; bit we; bit [AW-1:0] addr; bit [DW-1:0] wdata;
    bit busy; bit done; bit sv; bit [DW-1:0] sd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  bit            m_clear = 0, m_done = 0, m_sv = 0;
  bit [AW-1:0]   m_cnt = '0;
  bit [DW-1:0]   m_sd = '0;
  bit [DW-1:0]   mref [256];
  bit [AW+DW-1:0] fq[$];

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, predict the cycle's outcome.
  task automatic step(input bit rst, input bit sr, input bit [AW-1:0] sa,
                      input bit wv, input bit [AW-1:0] wa, input bit [DW-1:0] wd,
                      input bit cs, output bit acc);
    exp_t e;
    bit [DW-1:0] rd_val;
    @(negedge clk);
    rst_n = rst; scan_req = sr; scan_addr = sa; wr_valid = wv;
    wr_addr = wa; wr_data = wd; clr_start = cs;
    #1;
    e = '0;
    acc = 0;
    if (!rst) begin
      m_clear = 0; m_cnt = '0; m_done = 0; m_sv = 0; fq.delete();
      exp_q.push_back(e);
      return;
    end
    rd_val = mref[sa];
    e.rdy  = (fq.size() < DEPTH) && !m_clear && !cs;
    e.busy = m_clear; e.done = m_done; e.sv = m_sv; e.sd = m_sd;
    if (sr) begin
      e.en = 1; e.addr = sa;
    end else if (m_clear) begin
      e.en = 1; e.we = 1; e.addr = m_cnt; mref[m_cnt] = '0;
    end else if (!cs && fq.size() > 0) begin
      e.en = 1; e.we = 1; {e.addr, e.wdata} = fq.pop_front(); mref[e.addr] = e.wdata;
    end
    exp_q.push_back(e);
    m_sv = sr; m_sd = rd_val; m_done = 0;
    if (m_clear) begin
      if (!sr) begin
        if (m_cnt == 8'hFF) begin m_clear = 0; m_done = 1; end
        m_cnt++;
      end
    end else if (cs) begin
      fq.delete(); m_clear = 1;
    end
    if (wv && e.rdy) begin fq.push_back({wa, wd}); acc = 1; end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0, '0, 0, a);
  endtask

  exp_t me;
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("wr_ready", int'(wr_ready), int'(me.rdy));
      chk("mem_en", int'(mem_en), int'(me.en));
      chk("clr_busy", int'(clr_busy), int'(me.busy));
      chk("clr_done", int'(clr_done), int'(me.done));
      chk("scan_valid", int'(scan_valid), int'(me.sv));
      if (me.en) begin
        chk("mem_we", int'(mem_we), int'(me.we));
        chk("mem_addr", int'(mem_addr), int'(me.addr));
      end
      if (me.en && me.we) chk("mem_wdata", int'(mem_wdata), int'(me.wdata));
      if (me.sv) chk("scan_data", int'(scan_data), int'(me.sd));
    end
  end

  initial begin
    bit a;
    bit [AW-1:0] ad [3];
    int guard;
    for (int i = 0; i < 256; i++) begin ram[i] = '0; mref[i] = '0; end

    // reset values
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0, '0, 0, a);

    // single posted write, drains next cycle
    step(1, 0, '0, 1, 8'h12, 2'd3, 0, a);
    idle(3);

    // three writes under held scan: two accepted, then ordered drain
    for (int i = 0; i < 3; i++) begin
      ad[i] = AW'($urandom);
      step(1, 1, AW'($urandom), 1, ad[i], DW'(i + 1), 0, a);
    end
    step(1, 1, AW'($urandom), 0, '0, '0, 0, a);
    step(1, 0, '0, 1, ad[2], 2'd3, 0, a);
    idle(4);

    // write then read back address 0x05
    step(1, 0, '0, 1, 8'h05, 2'd1, 0, a);
    idle(2);
    step(1, 1, 8'h05, 0, '0, '0, 0, a);
    idle(2);

    // clear with two queued entries dropped
    step(1, 1, 8'h12, 1, 8'h40, 2'd2, 0, a);
    step(1, 1, 8'h05, 1, 8'h41, 2'd3, 0, a);
    step(1, 1, 8'h41, 0, '0, '0, 1, a);
    idle(262);
    step(1, 1, 8'h40, 0, '0, '0, 0, a);
    step(1, 1, 8'h41, 0, '0, '0, 0, a);

    // repopulate some pixels, then clear with a scan every 4th cycle
    for (int i = 0; i < 20; i++) step(1, 0, '0, 1, AW'($urandom), DW'($urandom), 0, a);
    idle(3);
    step(1, 0, '0, 0, '0, '0, 1, a);
    guard = 0;
    while (m_clear && guard < 600) begin
      step(1, (guard % 4) == 3, AW'($urandom), 0, '0, '0, (guard % 7) == 0, a);
      guard++;
    end
    idle(3);

    // reset in the middle of a clear
    for (int i = 0; i < 10; i++) step(1, 0, '0, 1, AW'(200 + i), 2'd2, 0, a);
    idle(3);
    step(1, 0, '0, 0, '0, '0, 1, a);
    guard = 0;
    while (m_cnt != 8'd100 && guard < 300) begin idle(1); guard++; end
    step(0, 0, '0, 0, '0, '0, 0, a);
    step(0, 0, '0, 0, '0, '0, 0, a);
    idle(3);
    for (int i = 0; i < 12; i++) step(1, 1, AW'(95 + i), 0, '0, '0, 0, a);
    step(1, 1, 8'd200, 0, '0, '0, 0, a);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(1, $urandom_range(0, 9) < 3, AW'($urandom), bit'($urandom_range(0, 1)),
           AW'($urandom), DW'($urandom), $urandom_range(0, 499) == 0, a);
    guard = 0;
    while ((m_clear || fq.size() > 0) && guard < 600) begin idle(1); guard++; end

    // read back the whole canvas
    for (int i = 0; i < 256; i++) step(1, 1, AW'(i), 0, '0, '0, 0, a);
    idle(3);

    @(negedge clk); #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/canvas_mem_arbiter.md
Name: canvas_mem_arbiter

Overview:
- Shares the single-port canvas pixel memory inside tt_um_canvas among three requesters: display scan-out reads, drawing-engine pixel writes, and a whole-canvas clear sequence.
- Scan reads take strict priority, since the display has a fixed deadline.
- Draw writes are posted through a small FIFO so the drawing engine rarely stalls.
- A clear FSM sweeps every address, writing colour 0.

Parameters:
- ADDR_W, 8, pixel address width (16x16 canvas = 256 pixels).
- DATA_W, 2, pixel colour width.
- FIFO_DEPTH, 2, write-post FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_req  in  1  display requests a read this cycle.
- scan_addr  in  ADDR_W  address to read.
- scan_valid  out  1  scan_data valid; registered copy of scan_req.
- scan_data  out  DATA_W  equals mem_rdata.
- wr_valid  in  1  draw engine offers a write.
- wr_ready  out  1  FIFO accepts the write.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write colour.
- clr_start  in  1  one-cycle pulse that starts a canvas clear.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous read data, valid 1 cycle after a read.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO empty, clear counter 0, FSM in IDLE.
  - Outputs: scan_valid=0, clr_busy=0, clr_done=0.
  - wr_ready and mem_en are forced 0 while rst_n is low.
- FSM states:
  - IDLE: drains the FIFO.
  - CLEAR: sweeps addresses.
  - IDLE -> CLEAR on clr_start.
  - CLEAR -> IDLE in the cycle after the write to address 2^ADDR_W-1; clr_done pulses in that cycle.
  - clr_start while in CLEAR is ignored.
- Per-cycle arbitration (combinational mem_* outputs):
  1. scan_req=1: mem_en=1, mem_we=0, mem_addr=scan_addr.
  2. Otherwise in CLEAR: mem_en=1, mem_we=1, mem_addr=clr_cnt, mem_wdata=0; clr_cnt increments.
  3. Otherwise in IDLE with FIFO non-empty: write the head entry, then pop.
  4. Otherwise mem_en=0.
- Scan path:
  - scan_valid is scan_req delayed 1 cycle; scan_data=mem_rdata passes through.
  - Read latency is 1 cycle.
  - A scan read is never stalled.
- Write FIFO:
  - wr_ready = (count < FIFO_DEPTH) && state==IDLE && !clr_start.
  - Push on wr_valid && wr_ready.
  - No bypass: a write pushed in cycle N reaches memory no earlier than N+1.
  - Simultaneous push and pop leaves count unchanged.
  - Entries are written in order.
- Clear:
  - On clr_start, all pending FIFO entries are discarded; they would be overwritten by the clear anyway.
  - clr_busy=1 throughout CLEAR.
  - Uncontended, the sweep takes 2^ADDR_W cycles; each scan_req cycle adds one stall cycle.
  - clr_cnt wraps to 0 at the end of the sweep.
- Hazard: a scan read of an address whose write is still in the FIFO returns the old value. This is accepted; the display updates on the next frame.
- Reset mid-clear or mid-drain aborts immediately. Memory contents are left partially written.

Test Plan:
- Reset, then wr_valid with addr=0x12, data=3 and no scan -> wr_ready=1; next cycle mem_en=1, mem_we=1, mem_addr=0x12, mem_wdata=3; FIFO empties.
- scan_req held high while pushing 3 writes -> 2 accepted, the third sees wr_ready=0; mem_we stays 0 until scan_req drops, then addresses are written in push order.
- scan_req addr=0x05 after writing 1 there -> scan_valid=1 one cycle later with scan_data=1.
- clr_start with 2 entries queued and no scan -> entries dropped, clr_busy=1 for 256 cycles, addresses 0..255 written with 0, then clr_done pulses once and clr_busy=0.
- clr_start with scan_req high on every 4th cycle -> clear takes 256 cycles plus the number of scan cycles; every scan read is served with 1-cycle latency.
- Assert rst_n=0 at clr_cnt=100 -> outputs at reset values immediately; after release FSM is in IDLE, wr_ready=1, and no clr_done pulse occurs.
